muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit, parametrised in data width, sitting beside the ALU in the EX stage of the five-stage pipeline. It accepts one M-extension operation (`op` 0110011, `fun7` 0000001) with forwarded operands and computes one bit per cycle. While it is busy it raises a stall to the PC and pipeline registers. It returns the result with the destination register for writeback, and it resolves divide-by-zero and signed overflow in a single cycle.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle results for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_fun3,
  input  logic [XLEN-1:0] i_rs1dat,
  input  logic [XLEN-1:0] i_rs2dat,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_block,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        fun3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              sign_a, sign_b, neg_start;
  logic              is_div, b_zero, div_ovf, fast_path, accept;
  logic [XLEN-1:0]   mag_a, mag_b, fast_result;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (i_fun3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a = i_rs1dat[XLEN-1];
        sign_b = i_rs2dat[XLEN-1];
      end
      3'b010:  sign_a = i_rs1dat[XLEN-1];
      default: ;
    endcase
  end

  assign mag_a     = sign_a ? -i_rs1dat : i_rs1dat;
  assign mag_b     = sign_b ? -i_rs2dat : i_rs2dat;
  // The remainder takes the dividend's sign; every other result the sign product.
  assign neg_start = (i_fun3 == 3'b110) ? sign_a : (sign_a ^ sign_b);

  assign is_div    = i_fun3[2];
  assign b_zero    = (i_rs2dat == '0);
  assign div_ovf   = !i_fun3[0] && (i_rs1dat == MOST_NEG) && (i_rs2dat == '1);
  assign fast_path = is_div && (b_zero || div_ovf);
  assign accept    = i_start && !i_flush;

  always_comb begin
    fast_result = '0;
    if (b_zero) begin
      fast_result = i_fun3[1] ? i_rs1dat : '1;
    end else if (!i_fun3[1]) begin
      fast_result = i_rs1dat;
    end
  end

  // One iteration: the low half of acc_q holds the multiplier (shifted out right)
  // or the dividend/quotient (shifted left); the high half holds product or remainder.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_new;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge      = (div_shift >= {1'b0, opnd_q});
    div_rem_new = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
    if (fun3_q[2]) begin
      acc_step = {div_rem_new, acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed, rem_signed, final_result;

  always_comb begin
    prod_signed = neg_q ? -acc_step : acc_step;
    quo_signed  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_signed  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (fun3_q)
      3'b000:                 final_result = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quo_signed;
      default:                final_result = rem_signed;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fun3_q   <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            fun3_q <= i_fun3;
            rd_q   <= i_rd;
            neg_q  <= neg_start;
            cnt_q  <= '0;
            if (is_div) begin
              opnd_q <= mag_b;
              acc_q  <= {{XLEN{1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {{XLEN{1'b0}}, mag_b};
            end
            if (fast_path) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= fast_result;
              rd_out_q <= i_rd;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= final_result;
              rd_out_q <= rd_q;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_block  = (state_q == BUSY) || ((state_q == IDLE) && accept);
  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_rd     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a transaction-level reference model checked every
// cycle, plus literal expectations for each directed operation.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            rst = 1'b0;
  logic            i_start = 1'b0;
  logic [2:0]      i_fun3 = '0;
  logic [XLEN-1:0] i_rs1dat = '0;
  logic [XLEN-1:0] i_rs2dat = '0;
  logic [4:0]      i_rd = '0;
  logic            i_flush = 1'b0;
  logic            o_block, o_busy, o_done;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clock    (clock),
    .rst      (rst),
    .i_start  (i_start),
    .i_fun3   (i_fun3),
    .i_rs1dat (i_rs1dat),
    .i_rs2dat (i_rs2dat),
    .i_rd     (i_rd),
    .i_flush  (i_flush),
    .o_block  (o_block),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_rd     (o_rd)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Transaction model: tracks whether an operation is outstanding and when it completes.
  logic        m_pending = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;

  initial begin
    forever begin
      @(posedge clock or negedge rst);
      if (!rst) begin
        m_pending = 1'b0; m_done = 1'b0; m_left = 0;
        exp_result = '0; exp_rd = '0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_pending) begin
        if (i_flush) begin
          m_pending = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_pending = 1'b0; m_done = 1'b1;
            exp_result = m_res; exp_rd = m_rd;
          end
        end
      end else if (i_start && !i_flush) begin
        if (ref_fast(i_fun3, i_rs1dat, i_rs2dat)) begin
          m_done = 1'b1;
          exp_result = ref_result(i_fun3, i_rs1dat, i_rs2dat);
          exp_rd = i_rd;
        end else begin
          m_pending = 1'b1; m_left = XLEN;
          m_res = ref_result(i_fun3, i_rs1dat, i_rs2dat);
          m_rd = i_rd;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_busy", {31'b0, o_busy}, {31'b0, m_pending || m_done});
      chk("cyc_done", {31'b0, o_done}, {31'b0, m_done});
      chk("cyc_block", {31'b0, o_block},
          {31'b0, m_pending || (!m_done && i_start && !i_flush)});
      chk("cyc_result", o_result, exp_result);
      chk("cyc_rd", {27'b0, o_rd}, {27'b0, exp_rd});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // One transaction: start pulse, optional stray start at cycle `poke`, bounded wait for done.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input int poke);
    int  lat, blk, c;
    bit  seen;
    lat = 0; blk = 0; c = 0; seen = 1'b0;
    @(posedge clock); #1;
    i_start = 1'b1; i_fun3 = f; i_rs1dat = a; i_rs2dat = b; i_rd = rd;
    @(negedge clock);
    if (o_block) blk++;
    while (!seen && c < 60) begin
      c++;
      @(posedge clock); #1;
      i_start = (c == poke);
      if (c == poke) begin
        i_fun3 = 3'b000; i_rs1dat = 32'h1234; i_rs2dat = 32'h5; i_rd = 5'd31;
      end
      @(negedge clock);
      if (o_done) begin
        seen = 1'b1; lat = c;
      end else if (o_block) begin
        blk++;
      end
    end
    i_start = 1'b0;
    chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_block_cycles"}, blk, exp_lat);
    chk({name, "_result"}, o_result, exp);
    chk({name, "_rd"}, {27'b0, o_rd}, {27'b0, rd});
    $display("op %-10s fun3=%0d a=%08h b=%08h rd=%0d -> result=%08h latency=%0d",
             name, f, a, b, rd, o_result, lat);
  endtask

  bit done_seen;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'b0, o_busy}, 32'd0);
    chk("reset_done", {31'b0, o_done}, 32'd0);
    chk("reset_block", {31'b0, o_block}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    chk("reset_rd", {27'b0, o_rd}, 32'd0);
    rst = 1'b1;
    @(negedge clock);

    run_op("mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 0);
    run_op("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33, 0);
    run_op("mulhu",    3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 33, 0);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 33, 0);
    run_op("mulhu_max",3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 33, 0);
    run_op("divu_z",   3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_z",    3'd6, 32'd5,         32'd0,         5'd11, 32'd5,         1, 0);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1, 0);
    run_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFF, 33, 0);
    run_op("remu",     3'd7, 32'hFFFF_FFF9, 32'd2,         5'd19, 32'd1,         33, 0);
    run_op("div_nb",   3'd4, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_nb",   3'd6, 32'd7,         32'hFFFF_FFFE, 5'd22, 32'd1,         33, 0);
    run_op("remu_z",   3'd7, 32'h1234_5678, 32'd0,         5'd23, 32'h1234_5678, 1, 0);
    run_op("div_z",    3'd4, 32'd123,       32'd0,         5'd24, 32'hFFFF_FFFF, 1, 0);
    run_op("mul_m1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'd1,         33, 0);

    // Flush in BUSY cycle 10, then a start that coincides with a flush in IDLE.
    @(posedge clock); #1;
    i_start = 1'b1; i_fun3 = 3'd0; i_rs1dat = 32'd3; i_rs2dat = 32'd5; i_rd = 5'd9;
    @(posedge clock); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    i_flush = 1'b1;
    @(negedge clock);
    chk("flush_busy_before", {31'b0, o_busy}, 32'd1);
    @(posedge clock); #1;
    i_start = 1'b1; i_fun3 = 3'd5; i_rs1dat = 32'd100; i_rs2dat = 32'd7; i_rd = 5'd2;
    @(negedge clock);
    chk("flush_idle_busy", {31'b0, o_busy}, 32'd0);
    chk("flush_start_block", {31'b0, o_block}, 32'd0);
    @(posedge clock); #1;
    i_flush = 1'b0; i_start = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (o_done) done_seen = 1'b1;
    end
    chk("flush_no_done", {31'b0, done_seen}, 32'd0);
    chk("flush_still_idle", {31'b0, o_busy}, 32'd0);
    chk("flush_result_held", o_result, 32'd1);
    chk("flush_rd_held", {27'b0, o_rd}, 32'd21);
    $display("op flush     busy cycle 10 -> idle, result held=%08h rd=%0d", o_result, o_rd);

    // Asynchronous reset at BUSY cycle 5, then relaunch with a stray start mid-operation.
    @(posedge clock); #1;
    i_start = 1'b1; i_fun3 = 3'd0; i_rs1dat = 32'h1234; i_rs2dat = 32'h10; i_rd = 5'd7;
    @(posedge clock); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("rstmid_busy_before", {31'b0, o_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_busy", {31'b0, o_busy}, 32'd0);
    chk("rstmid_done", {31'b0, o_done}, 32'd0);
    chk("rstmid_block", {31'b0, o_block}, 32'd0);
    chk("rstmid_result", o_result, 32'd0);
    chk("rstmid_rd", {27'b0, o_rd}, 32'd0);
    $display("op reset     mid-operation -> outputs cleared");
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    @(negedge clock);

    run_op("divu_poke", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33, 3);
    run_op("mul_b2b",   3'd0, 32'd6,   32'd7, 5'd1,  32'd42, 33, 0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
